// File: rtl/noc_stat_pkg.sv
// Shared widths, router count and FSM state encoding for the NoC statistics collector.
package noc_stat_pkg;

    localparam int ROUTERS = 9;
    localparam int LAT_W   = 10;
    localparam int SUM_W   = 28;
    localparam int GSUM_W  = 32;
    localparam int CNT_W   = 4;
    localparam int TOT_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SCAN,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/noc_serial_div.sv
// Restoring divider, one quotient bit per cycle, W cycles per divide.
module noc_serial_div #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  rem, rem_src, rem_nx;
    logic [W-1:0]  q, q_src, q_nx;
    logic [W-1:0]  den, den_src;
    logic [W:0]    shifted;
    logic          fits;
    logic [CW-1:0] count;
    logic          running;

    // The start edge already performs the first iteration on the incoming
    // operands, so done rises W edges after start.
    always_comb begin
        rem_src = start ? '0 : rem;
        q_src   = start ? dividend : q;
        den_src = start ? divisor : den;
        shifted = {rem_src, q_src[W-1]};
        fits    = shifted >= {1'b0, den_src};
        rem_nx  = fits ? W'(shifted - {1'b0, den_src}) : shifted[W-1:0];
        q_nx    = {q_src[W-2:0], fits};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            q       <= '0;
            den     <= '0;
            count   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else if (start) begin
            rem     <= rem_nx;
            q       <= q_nx;
            den     <= divisor;
            count   <= CW'(1);
            running <= 1'b1;
            done    <= 1'b0;
        end else if (running) begin
            rem   <= rem_nx;
            q     <= q_nx;
            count <= count + CW'(1);
            if (count == CW'(W - 1)) begin
                running <= 1'b0;
                done    <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign quotient = q;

endmodule

// File: rtl/noc_stat_collector.sv
// Waits for all routers to finish (or a timeout), scans their latency stats and reports min/max/sum/average.
module noc_stat_collector #(
    parameter int ROUTERS        = noc_stat_pkg::ROUTERS,
    parameter int LAT_W          = noc_stat_pkg::LAT_W,
    parameter int SUM_W          = noc_stat_pkg::SUM_W,
    parameter int GSUM_W         = noc_stat_pkg::GSUM_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic                                   flush,
    input  logic [ROUTERS-1:0]                     task_receive_finish_flag,
    input  logic [ROUTERS*noc_stat_pkg::CNT_W-1:0] receive_num,
    input  logic [ROUTERS*LAT_W-1:0]               latency_min,
    input  logic [ROUTERS*LAT_W-1:0]               latency_max,
    input  logic [ROUTERS*SUM_W-1:0]               latency_sum,
    output logic                                   stat_busy,
    output logic                                   stat_valid,
    output logic                                   stat_timeout,
    output logic [LAT_W-1:0]                       global_min,
    output logic [LAT_W-1:0]                       global_max,
    output logic [GSUM_W-1:0]                      global_sum,
    output logic [noc_stat_pkg::TOT_W-1:0]         total_received,
    output logic [GSUM_W-1:0]                      avg_latency,
    output logic [15:0]                            run_cycles
);
    import noc_stat_pkg::*;

    state_t            state, next_state;
    logic [3:0]        scan_idx;
    logic [CNT_W-1:0]  sel_num;
    logic [LAT_W-1:0]  sel_min, sel_max;
    logic [SUM_W-1:0]  sel_sum;
    logic [GSUM_W-1:0] sum_next;
    logic [TOT_W-1:0]  tot_next;
    logic              all_flags, timeout_hit, last_idx;
    logic              busy_next, valid_next, div_start, div_done;
    logic [GSUM_W-1:0] div_quot;

    always_comb begin
        sel_num = '0;
        sel_min = '0;
        sel_max = '0;
        sel_sum = '0;
        for (int unsigned i = 0; i < ROUTERS; i++) begin
            if (scan_idx == 4'(i)) begin
                sel_num = receive_num[i*CNT_W +: CNT_W];
                sel_min = latency_min[i*LAT_W +: LAT_W];
                sel_max = latency_max[i*LAT_W +: LAT_W];
                sel_sum = latency_sum[i*SUM_W +: SUM_W];
            end
        end
    end

    assign all_flags   = &task_receive_finish_flag;
    assign timeout_hit = run_cycles == 16'(TIMEOUT_CYCLES - 1);
    assign last_idx    = scan_idx == 4'(ROUTERS - 1);
    assign sum_next    = global_sum + GSUM_W'(sel_sum);
    assign tot_next    = total_received + TOT_W'(sel_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (enable) next_state = S_WAIT;
            S_WAIT: begin
                if (!enable)                       next_state = S_IDLE;
                else if (all_flags || timeout_hit) next_state = S_SCAN;
            end
            S_SCAN: begin
                if (!enable)       next_state = S_IDLE;
                else if (last_idx) next_state = (tot_next != '0) ? S_DIV : S_DONE;
            end
            S_DIV: begin
                if (!enable)       next_state = S_IDLE;
                else if (div_done) next_state = S_DONE;
            end
            S_DONE:  if (!enable) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (flush) next_state = S_IDLE;
    end

    always_comb begin
        busy_next  = (next_state == S_WAIT) || (next_state == S_SCAN) || (next_state == S_DIV);
        valid_next = next_state == S_DONE;
        div_start  = (state == S_SCAN) && (next_state == S_DIV);
    end

    // Divider is launched on the last scan edge with the final sum/count.
    noc_serial_div #(
        .W(GSUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (sum_next),
        .divisor  (GSUM_W'(tot_next)),
        .quotient (div_quot),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_busy      <= 1'b0;
            stat_valid     <= 1'b0;
            stat_timeout   <= 1'b0;
            global_min     <= '0;
            global_max     <= '0;
            global_sum     <= '0;
            total_received <= '0;
            avg_latency    <= '0;
            run_cycles     <= '0;
            scan_idx       <= '0;
        end else begin
            stat_busy  <= busy_next;
            stat_valid <= valid_next;
            if (next_state == S_IDLE) begin
                stat_timeout   <= 1'b0;
                global_min     <= '0;
                global_max     <= '0;
                global_sum     <= '0;
                total_received <= '0;
                avg_latency    <= '0;
                run_cycles     <= '0;
                scan_idx       <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        global_min <= '1;
                        run_cycles <= '0;
                    end
                    S_WAIT: begin
                        if (run_cycles != '1) run_cycles <= run_cycles + 16'd1;
                        if (next_state == S_SCAN) begin
                            stat_timeout <= !all_flags;
                            scan_idx     <= '0;
                        end
                    end
                    S_SCAN: begin
                        global_sum     <= sum_next;
                        total_received <= tot_next;
                        scan_idx       <= scan_idx + 4'd1;
                        if (sel_num != '0) begin
                            if (sel_min < global_min) global_min <= sel_min;
                            if (sel_max > global_max) global_max <= sel_max;
                        end
                        if (next_state == S_DONE) global_min <= '0;
                    end
                    S_DIV: if (next_state == S_DONE) avg_latency <= div_quot;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/noc_stat_collector.md
# noc_stat_collector

Downstream consumer of `noc_top`'s per-router result outputs for the 3x3 mesh. After a traffic run starts, it waits until all nine routers report receive-complete, or until a timeout. It then scans the nine routers' latency statistics one per cycle and reduces them to network-wide min, max, sum and total packet count. A serial divide produces the average latency, and the result is presented with a level `stat_valid`.

## Interface
Parameters:
- `ROUTERS`, 9: number of routers scanned; index i = row*3+col, router 00 = index 0.
- `LAT_W`, 10: per-router latency min/max width (`TIME_SIZE`).
- `SUM_W`, 28: per-router latency sum width (`TIME_SUM_SIZE + LOG_ROUTER_NUM`).
- `GSUM_W`, 32: global sum / average width.
- `TIMEOUT_CYCLES`, 1023: maximum WAIT cycles before a forced scan.

Ports (all buses packed with index 0 in the LSBs):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; same signal that drives `noc_top`.
- `flush` in 1: synchronous abort to IDLE.
- `task_receive_finish_flag` in 9: per-router receive-complete.
- `receive_num` in 36: 9x4-bit received-packet counts.
- `latency_min` in 90: 9xLAT_W.
- `latency_max` in 90: 9xLAT_W.
- `latency_sum` in 252: 9xSUM_W.
- `stat_busy` out 1: high in WAIT/SCAN/DIV.
- `stat_valid` out 1: high in DONE.
- `stat_timeout` out 1: run ended by timeout.
- `global_min` out 10.
- `global_max` out 10.
- `global_sum` out 32.
- `total_received` out 8.
- `avg_latency` out 32: floor(global_sum / total_received).
- `run_cycles` out 16: WAIT cycles elapsed, saturating at 16'hFFFF.

## Operation
- FSM states: IDLE, WAIT, SCAN, DIV, DONE.
- IDLE: all accumulators cleared. `enable`=1 → WAIT.
- WAIT: `run_cycles` increments each cycle. Exit to SCAN when either condition holds:
  - all 9 finish flags are sampled high, with `stat_timeout`=0; or
  - `run_cycles` == TIMEOUT_CYCLES-1, with `stat_timeout`=1.
  - If both occur on the same edge, the flags win (`stat_timeout`=0).
- SCAN: 4-bit index 0..8, one router per cycle.
  - `global_sum` += zero-extended `latency_sum[i]`.
  - `total_received` += `receive_num[i]`.
  - min/max are updated only if `receive_num[i]` != 0.
  - At index 8, go to DIV if `total_received` is nonzero (including the index-8 add), else to DONE with `avg_latency`=0.
- DIV: 32-iteration restoring division of `global_sum` by zero-extended `total_received`, one quotient bit per cycle. Then → DONE.
- DONE: outputs frozen. `enable`=0 → IDLE. Outputs keep their values until the IDLE entry edge clears them.
- `flush`=1 in any state → IDLE on that edge, all outputs cleared. `flush` has priority over every transition.
- `enable` dropping in WAIT/SCAN/DIV → IDLE, all outputs cleared (aborted run).
- Min/max accumulation:
  - `global_min` initialises to 10'h3FF and `global_max` to 0.
  - If no router received packets, `global_min` is forced to 0 on entering DONE.
- Widths: max `total_received` = 135, which fits 8 bits. Max `global_sum` = 9*(2^28-1) < 2^32, so no overflow is possible.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, `global_min` 0 (the 3FF initialisation applies on WAIT entry).
- `stat_busy` rises on the edge after `enable` is sampled high in IDLE.
- Let edge t be the edge at which WAIT samples all flags high. Then:
  - SCAN processes index i at edge t+1+i.
  - DIV occupies edges t+10..t+41.
  - `stat_valid` is high after edge t+41, and `stat_busy` falls on that same edge.
- Zero-packet path: `stat_valid` is high after edge t+9.
- The input buses must be stable from t through t+9. The block does not re-sample them in DIV.
- Timeout: SCAN begins on the edge where `run_cycles` reaches TIMEOUT_CYCLES.

## Structure
- Shared package `noc_stat_pkg` holds:
  - widths: `LAT_W`, `SUM_W`, `GSUM_W`, `CNT_W`=4, `TOT_W`=8;
  - the FSM state enum;
  - the `ROUTERS` constant.
- Sub-module `noc_serial_div`: a 32-bit restoring divider with `start`/`done`, quotient only, and a fixed 32 cycles.
- Top level contains the FSM, scan index mux, accumulators and the WAIT counter.

## Test plan
- Uniform run:
  - stimulus: `receive_num`=1 and `latency_min`=`latency_max`=`latency_sum`=10+i for every router; flags all raised together;
  - required response: `global_min`=10, `global_max`=18, `global_sum`=126, `total_received`=9, `avg_latency`=14, `stat_valid` 41 edges after t.
- Zero packets:
  - stimulus: all `receive_num`=0, flags high;
  - required response: min=max=sum=avg=0, `total_received`=0, `stat_valid` after edge t+9.
- Timeout:
  - stimulus: TIMEOUT_CYCLES=20 and one flag held low;
  - required response: `stat_timeout`=1, `run_cycles`=20, a scan completes normally.
- Flush mid-DIV:
  - stimulus: `flush` pulsed at edge t+20;
  - required response: IDLE at the next sample, every output 0; a new `enable` run then completes correctly.
- Rounding and skipping:
  - stimulus: router 4 has `receive_num`=15, `latency_sum`=1000, min 40, max 99; router 7 has `receive_num`=2, sum 7, min 3, max 4; all others have 0 packets but max 1023;
  - required response: min 3, max 99, sum 1007, total 17, avg 59.
- Flag/timeout collision and enable drop:
  - stimulus 1: flags complete on the timeout edge → required response: `stat_timeout`=0.
  - stimulus 2: `enable` dropped during SCAN → required response: IDLE, outputs cleared.
